// File: rtl/ssd_word_sched_if.sv
// ssd_word_sched_if
// Bundles the request side and the display side of the seven-segment word
// scheduler.
//   req        : level request per source, held until that source's ack
//   req_data   : source i word at [32*i+31:32*i]
//   hold       : freezes the dwell counter while high
//   disp_word  : word shown on the display, nibble k drives digit k
//   disp_blank : 1 = digit k blanked
//   disp_src   : source currently (or last) displayed
//   disp_valid : disp_word holds granted data
//   ack        : one-cycle pulse to the granted source at end of dwell
//   busy       : scheduler is showing a word or acknowledging it
// slave  modport: the scheduler.
// master modport: the requesters / display consumer.
interface ssd_word_sched_if;
    logic [3:0]   req;
    logic [127:0] req_data;
    logic         hold;
    logic [31:0]  disp_word;
    logic [7:0]   disp_blank;
    logic [1:0]   disp_src;
    logic         disp_valid;
    logic [3:0]   ack;
    logic         busy;

    modport slave (
        input  req, req_data, hold,
        output disp_word, disp_blank, disp_src, disp_valid, ack, busy
    );

    modport master (
        output req, req_data, hold,
        input  disp_word, disp_blank, disp_src, disp_valid, ack, busy
    );
endinterface

// File: rtl/ssd_word_sched.sv
// ssd_word_sched
// Round-robin scheduler sharing the 8-digit seven-segment display between
// four requesters. One 32-bit word is granted at a time and held for DWELL
// clk cycles (plus any cycles with hold high), then the source is acked.
// Ports:
//   clk : system clock, rising edge
//   rst : asynchronous, active-high reset
//   bus : ssd_word_sched_if.slave (request inputs, display outputs)
// Parameters:
//   DWELL : display time per grant in clk cycles (>= 1)
//   CNT_W : dwell counter width, 2**CNT_W > DWELL
// Build option:
//   SSD_SCHED_LZB_EN : when defined, leading-zero digits are blanked at
//                      grant; otherwise disp_blank is 8'h00 at every grant.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no grant; last word stays visible; looking for a request
// SHOW  | word granted and displayed; dwell counter running
// DONE  | dwell complete; ack pulses to the granted source for 1 cycle
module ssd_word_sched #(
    parameter int DWELL = 100_000_000,
    parameter int CNT_W = 27
) (
    input  logic                clk,
    input  logic                rst,
    ssd_word_sched_if.slave     bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SHOW = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        word_q, word_d;
    logic [7:0]         blank_q, blank_d;
    logic [1:0]         src_q, src_d;
    logic               valid_q, valid_d;
    logic [3:0]         ack_q, ack_d;
    logic               busy_q, busy_d;
    logic [1:0]         last_q, last_d;

    logic [1:0]         pick;
    logic [1:0]         idx;
    logic               hit;
    logic [31:0]        word_sel;

`ifdef SSD_SCHED_LZB_EN
    // Digit k is blanked only when it and every more significant digit are
    // zero; digit 0 always shows so an all-zero word still reads "0".
    function automatic logic [7:0] lzb_of(input logic [31:0] w);
        logic [7:0] b;
        logic       zero_above;
        b          = 8'h00;
        zero_above = 1'b1;
        for (int k = 7; k >= 1; k--) begin
            zero_above = zero_above & (w[4*k +: 4] == 4'h0);
            b[k]       = zero_above;
        end
        return b;
    endfunction
`endif

    // Round-robin pick: search starts one past the last grant and wraps.
    always_comb begin
        pick = 2'd0;
        hit  = 1'b0;
        idx  = 2'd0;
        for (int i = 1; i <= 4; i++) begin
            idx = last_q + 2'(i);
            if (!hit && bus.req[idx]) begin
                hit  = 1'b1;
                pick = idx;
            end
        end
    end

    assign word_sel = bus.req_data[32*pick +: 32];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        word_d  = word_q;
        blank_d = blank_q;
        src_d   = src_q;
        valid_d = valid_q;
        ack_d   = 4'b0000;
        busy_d  = busy_q;
        last_d  = last_q;

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (hit) begin
                    state_d = SHOW;
                    cnt_d   = '0;
                    word_d  = word_sel;
`ifdef SSD_SCHED_LZB_EN
                    blank_d = lzb_of(word_sel);
`else
                    blank_d = 8'h00;
`endif
                    src_d   = pick;
                    valid_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            SHOW: begin
                busy_d = 1'b1;
                if (!bus.hold) begin
                    if (cnt_q == CNT_W'(DWELL - 1)) begin
                        // ack is registered, so it is raised on entry to DONE
                        state_d = DONE;
                        ack_d   = 4'b0001 << src_q;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                last_d  = src_q;
                busy_d  = 1'b0;
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            word_q  <= 32'h0000_0000;
            blank_q <= 8'hFF;
            src_q   <= 2'd0;
            valid_q <= 1'b0;
            ack_q   <= 4'b0000;
            busy_q  <= 1'b0;
            last_q  <= 2'd3;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            word_q  <= word_d;
            blank_q <= blank_d;
            src_q   <= src_d;
            valid_q <= valid_d;
            ack_q   <= ack_d;
            busy_q  <= busy_d;
            last_q  <= last_d;
        end
    end

    assign bus.disp_word  = word_q;
    assign bus.disp_blank = blank_q;
    assign bus.disp_src   = src_q;
    assign bus.disp_valid = valid_q;
    assign bus.ack        = ack_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_ssd_word_sched.sv
module tb_ssd_word_sched;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;
    int   cyc;

    ssd_word_sched_if bus ();

    ssd_word_sched #(.DWELL(4), .CNT_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  mask;
        logic [31:0] word;
        logic [1:0]  src;
        logic [7:0]  blank_lzb;
    } vec_t;

    vec_t vecs[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Ticks until an ack bit is seen or the budget runs out; n = ticks taken.
    task automatic wait_ack(input int budget, output int n);
        n = 0;
        do begin
            tick();
            n++;
        end while (bus.ack == 4'b0000 && n < budget);
    endtask

    function automatic logic [7:0] exp_blank(input logic [7:0] lzb);
`ifdef SSD_SCHED_LZB_EN
        return lzb;
`else
        return 8'h00;
`endif
    endfunction

    initial begin
        int          n;
        int          gcyc;
        int          prev_gcyc;
        logic [31:0] held;

        n_cmp = 0;
        n_fail = 0;
        cyc = 0;
        prev_gcyc = 0;

        vecs[0] = '{mask: 4'b1111, word: 32'h0000_12AB, src: 2'd0, blank_lzb: 8'hF0};
        vecs[1] = '{mask: 4'b1110, word: 32'h0000_0000, src: 2'd1, blank_lzb: 8'hFE};
        vecs[2] = '{mask: 4'b1100, word: 32'h8000_0000, src: 2'd2, blank_lzb: 8'h00};
        vecs[3] = '{mask: 4'b1000, word: 32'h0000_0001, src: 2'd3, blank_lzb: 8'hFE};
        vecs[4] = '{mask: 4'b0101, word: 32'h00AB_CDEF, src: 2'd0, blank_lzb: 8'hC0};
        vecs[5] = '{mask: 4'b0100, word: 32'h0F00_0000, src: 2'd2, blank_lzb: 8'h80};

        // reset before any clock edge
        rst = 1'b1;
        bus.req = 4'b0000;
        bus.req_data = '0;
        bus.hold = 1'b0;
        #2;
        chk("rst_word",  bus.disp_word, 32'h0);
        chk("rst_blank", 32'(bus.disp_blank), 32'hFF);
        chk("rst_src",   32'(bus.disp_src), 32'h0);
        chk("rst_valid", 32'(bus.disp_valid), 32'h0);
        chk("rst_ack",   32'(bus.ack), 32'h0);
        chk("rst_busy",  32'(bus.busy), 32'h0);
        tick();
        rst = 1'b0;

        // round robin and blanking table
        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < 4; i++)
                bus.req_data[32*i +: 32] = (i == int'(vecs[v].src)) ? vecs[v].word
                                                                   : (32'hDEAD_0000 | 32'(i));
            bus.req = vecs[v].mask;
            tick();
            gcyc = cyc;
            chk("grant_src",   32'(bus.disp_src), 32'(vecs[v].src));
            chk("grant_word",  bus.disp_word, vecs[v].word);
            chk("grant_blank", 32'(bus.disp_blank), 32'(exp_blank(vecs[v].blank_lzb)));
            chk("grant_valid", 32'(bus.disp_valid), 32'h1);
            chk("grant_busy",  32'(bus.busy), 32'h1);
            chk("grant_ack",   32'(bus.ack), 32'h0);
            if (v >= 1 && v <= 3)
                chk("grant_spacing", 32'(gcyc - prev_gcyc), 32'd6);
            prev_gcyc = gcyc;
            bus.req_data = '1;
            wait_ack(20, n);
            chk("dwell_len", 32'(n), 32'd4);
            chk("ack_bit",   32'(bus.ack), 32'(4'b0001 << vecs[v].src));
            chk("word_held", bus.disp_word, vecs[v].word);
            bus.req = bus.req & ~(4'b0001 << vecs[v].src);
            tick();
            chk("ack_one_cycle", 32'(bus.ack), 32'h0);
            chk("idle_busy",     32'(bus.busy), 32'h0);
        end

        // hold for 3 cycles during SHOW delays ack by 3
        bus.req_data = '0;
        bus.req_data[31:0] = 32'hCAFE_0042;
        bus.req = 4'b0001;
        tick();
        chk("hold_grant_src", 32'(bus.disp_src), 32'h0);
        held = 32'hCAFE_0042;
        tick();
        bus.hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("hold_word_stable", bus.disp_word, held);
            chk("hold_no_ack", 32'(bus.ack), 32'h0);
        end
        bus.hold = 1'b0;
        wait_ack(20, n);
        chk("hold_dwell_len", 32'(n + 4), 32'd7);
        chk("hold_ack", 32'(bus.ack), 32'b0001);
        bus.req = 4'b0000;
        tick();
        chk("hold_ack_done", 32'(bus.ack), 32'h0);

        // req dropped during SHOW still completes; data sampled only at grant
        bus.req_data[63:32] = 32'h1234_5678;
        bus.req = 4'b0010;
        tick();
        chk("drop_grant_src", 32'(bus.disp_src), 32'h1);
        bus.req = 4'b0000;
        bus.req_data[63:32] = 32'hFFFF_0000;
        wait_ack(20, n);
        chk("drop_dwell_len", 32'(n), 32'd4);
        chk("drop_ack", 32'(bus.ack), 32'b0010);
        chk("drop_word", bus.disp_word, 32'h1234_5678);
        bus.hold = 1'b1;
        tick();
        chk("done_hold_ack", 32'(bus.ack), 32'h0);
        chk("done_hold_busy", 32'(bus.busy), 32'h0);
        tick();
        chk("idle_keep_word", bus.disp_word, 32'h1234_5678);
        chk("idle_keep_valid", 32'(bus.disp_valid), 32'h1);
        chk("idle_hold_busy", 32'(bus.busy), 32'h0);
        bus.hold = 1'b0;

        // abort by reset mid-SHOW, then req0 first after release
        bus.req_data[31:0]  = 32'hAAAA_0000;
        bus.req_data[95:64] = 32'hBBBB_0000;
        bus.req = 4'b0101;
        tick();
        chk("abort_grant_src", 32'(bus.disp_src), 32'h2);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("abort_word",  bus.disp_word, 32'h0);
        chk("abort_blank", 32'(bus.disp_blank), 32'hFF);
        chk("abort_src",   32'(bus.disp_src), 32'h0);
        chk("abort_valid", 32'(bus.disp_valid), 32'h0);
        chk("abort_busy",  32'(bus.busy), 32'h0);
        chk("abort_ack",   32'(bus.ack), 32'h0);
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("abort_no_ack", 32'(bus.ack), 32'h0);
        end
        rst = 1'b0;
        tick();
        chk("post_rst_src",  32'(bus.disp_src), 32'h0);
        chk("post_rst_word", bus.disp_word, 32'hAAAA_0000);
        wait_ack(20, n);
        chk("post_rst_dwell", 32'(n), 32'd4);
        chk("post_rst_ack", 32'(bus.ack), 32'b0001);
        bus.req = 4'b0000;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
